sid_i2s_tx: RTL and testbench



---
 rtl/sid_pkg.sv | 16 +
 rtl/sid_i2s_clkgen.sv | 35 +++
 rtl/sid_i2s_tx.sv | 115 +++++++++++
 tb/tb_sid_i2s_tx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
// Shared SID audio-path types: the stereo sample from the API block and the
// board-level I2S pin bundle.
package sid;

  typedef struct packed {
    logic signed [23:0] left;
    logic signed [23:0] right;
  } audio_t;

  typedef struct packed {
    logic bclk;
    logic lrclk;
    logic sdata;
  } i2s_o_t;

endpackage

// File: rtl/sid_i2s_clkgen.sv
// BCLK generator for the I2S transmitter: divides clk by 2*CLK_DIV and flags
// the clk edge on which BCLK falls (the shift event).
module sid_i2s_clkgen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic o_bclk,
  output logic o_shift
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] r_div_cnt;
  logic       r_bclk;
  logic       w_wrap;

  assign w_wrap  = (r_div_cnt == DIV_LAST);
  // Asserted in the cycle whose closing edge drives BCLK from 1 to 0.
  assign o_shift = w_wrap & r_bclk;
  assign o_bclk  = r_bclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= 8'd0;
      r_bclk    <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= 8'd0;
      r_bclk    <= ~r_bclk;
    end else begin
      r_div_cnt <= r_div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// Stereo Philips-I2S transmitter: 64-BCLK frames, 32 slots per channel,
// 24-bit samples sent MSB-first one BCLK after each LRCLK transition.
import sid::*;

module sid_i2s_tx #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  audio_t audio_i,
  input  logic   sample_valid,
  output logic   sample_taken,
  output logic   i2s_bclk,
  output logic   i2s_lrclk,
  output logic   i2s_sdata
);

  localparam int unsigned I2S_SLOT_BITS = 32;
  localparam int unsigned I2S_DATA_BITS = 24;
  localparam int unsigned SLOT_W        = $clog2(I2S_SLOT_BITS);
  localparam logic [SLOT_W-1:0] DATA_BITS_W = SLOT_W'(I2S_DATA_BITS);

  logic              w_shift;
  logic              w_bclk;
  logic              w_frame_load;
  logic [5:0]        r_bit_cnt;
  logic [5:0]        w_next_bit;
  logic              w_chan;
  logic [SLOT_W-1:0] w_slot_pos;
  logic [SLOT_W-1:0] w_bit_idx;
  logic              w_sdata_next;
  audio_t            r_pend;
  logic [23:0]       r_left_sh;
  logic [23:0]       r_right_sh;
  logic              r_lrclk;
  logic              r_sdata;
  logic              r_taken;

  sid_i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .o_bclk  (w_bclk),
    .o_shift (w_shift)
  );

  assign w_next_bit   = r_bit_cnt + 6'd1;
  assign w_chan       = w_next_bit[SLOT_W];
  assign w_slot_pos   = w_next_bit[SLOT_W-1:0];
  assign w_bit_idx    = DATA_BITS_W - w_slot_pos;
  assign w_frame_load = w_shift & (r_bit_cnt == 6'd63);

  // Slot position 0 is the I2S one-bit delay; positions past the data width pad with zeros.
  always_comb begin
    w_sdata_next = 1'b0;
    if ((w_slot_pos != '0) && (w_slot_pos <= DATA_BITS_W)) begin
      if (w_chan) begin
        w_sdata_next = r_right_sh[w_bit_idx];
      end else begin
        w_sdata_next = r_left_sh[w_bit_idx];
      end
    end else begin
      w_sdata_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else if (sample_valid) begin
      r_pend <= audio_i;
    end
  end

  // A sample arriving on the load cycle bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_left_sh  <= 24'd0;
      r_right_sh <= 24'd0;
    end else if (w_frame_load) begin
      if (sample_valid) begin
        r_left_sh  <= audio_i.left;
        r_right_sh <= audio_i.right;
      end else begin
        r_left_sh  <= r_pend.left;
        r_right_sh <= r_pend.right;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt <= 6'd63;
      r_lrclk   <= 1'b1;
      r_sdata   <= 1'b0;
    end else if (w_shift) begin
      r_bit_cnt <= w_next_bit;
      r_lrclk   <= w_chan;
      r_sdata   <= w_sdata_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken <= 1'b0;
    end else begin
      r_taken <= w_frame_load;
    end
  end

  assign sample_taken = r_taken;
  assign i2s_bclk     = w_bclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_sdata    = r_sdata;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx: frames are decoded on BCLK rising edges and
// compared against expected sample pairs queued when the stimulus is driven.
module tb_sid_i2s_tx;
  import sid::*;

  logic   clk = 1'b0;
  logic   rst4 = 1'b1;
  logic   rst1 = 1'b1;
  audio_t audio;
  logic   valid;
  logic   taken4, bclk4, lr4, sd4;
  logic   taken1, bclk1, lr1, sd1;
  logic   sel;
  logic   m_taken, m_bclk, m_lrclk, m_sdata;

  int n_cmp;
  int n_fail;
  logic [47:0] exp_q[$];

  sid_i2s_tx #(.CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst4), .audio_i(audio), .sample_valid(valid),
    .sample_taken(taken4), .i2s_bclk(bclk4), .i2s_lrclk(lr4), .i2s_sdata(sd4)
  );

  sid_i2s_tx #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .audio_i(audio), .sample_valid(valid),
    .sample_taken(taken1), .i2s_bclk(bclk1), .i2s_lrclk(lr1), .i2s_sdata(sd1)
  );

  assign m_taken = sel ? taken1 : taken4;
  assign m_bclk  = sel ? bclk1  : bclk4;
  assign m_lrclk = sel ? lr1    : lr4;
  assign m_sdata = sel ? sd1    : sd4;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for a frame start, then records sdata/lrclk on the next n BCLK rises.
  task automatic collect(input int n, output logic [63:0] bits, output int span,
                         output logic lr_ok, output logic timed_out);
    int budget;
    int cyc;
    int k;
    logic prev;
    bits = '0; span = 0; lr_ok = 1'b1; timed_out = 1'b0; budget = 0;
    while (!m_taken && budget < 2000) begin
      tick();
      budget++;
    end
    if (!m_taken) begin
      timed_out = 1'b1;
      return;
    end
    prev = m_bclk; cyc = 0; k = 0;
    while (k < n && cyc < 20000) begin
      tick();
      cyc++;
      if (m_bclk && !prev) begin
        bits[63-k] = m_sdata;
        if (m_lrclk !== 1'(k >= 32)) lr_ok = 1'b0;
        span = cyc;
        k++;
      end
      prev = m_bclk;
    end
    if (k < n) timed_out = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int div);
    logic [63:0] bits;
    logic [63:0] want;
    logic [47:0] e;
    int span;
    logic lr_ok;
    logic to;
    collect(64, bits, span, lr_ok, to);
    chk({tag, "_timeout"}, 64'(to), 64'd0);
    e = exp_q.pop_front();
    want = {1'b0, e[47:24], 7'd0, 1'b0, e[23:0], 7'd0};
    chk({tag, "_bits"}, bits, want);
    chk({tag, "_lrclk"}, 64'(lr_ok), 64'd1);
    chk({tag, "_span"}, 64'(span), 64'(127 * div));
  endtask

  task automatic pulse(input logic [23:0] l, input logic [23:0] r);
    audio = {l, r};
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  // Called right after a frame's last BCLK rise: lands sample_valid on the load edge.
  task automatic collide(input int div, input logic [23:0] l, input logic [23:0] r);
    for (int i = 0; i < div - 1; i++) tick();
    pulse(l, r);
  endtask

  task automatic release_and_check_start(input string tag);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 3) chk({tag, "_bclk_c3"}, 64'(m_bclk), 64'd0);
      if (c == 4) chk({tag, "_bclk_c4"}, 64'(m_bclk), 64'd1);
      if (c == 7) chk({tag, "_taken_c7"}, 64'(m_taken), 64'd0);
      if (c == 7) chk({tag, "_lrclk_c7"}, 64'(m_lrclk), 64'd1);
    end
    chk({tag, "_taken_c8"}, 64'(m_taken), 64'd1);
    chk({tag, "_lrclk_c8"}, 64'(m_lrclk), 64'd0);
    chk({tag, "_bclk_c8"}, 64'(m_bclk), 64'd0);
  endtask

  initial begin
    logic [63:0] bits;
    int span;
    logic lr_ok;
    logic to;
    n_cmp = 0; n_fail = 0; sel = 1'b0; valid = 1'b0; audio = '0;

    repeat (3) tick();
    chk("rst_bclk", 64'(m_bclk), 64'd0);
    chk("rst_lrclk", 64'(m_lrclk), 64'd1);
    chk("rst_sdata", 64'(m_sdata), 64'd0);
    chk("rst_taken", 64'(m_taken), 64'd0);

    rst4 = 1'b0;
    release_and_check_start("start");
    exp_q.push_back(48'd0);
    check_frame("zero", 4);

    pulse(24'h800001, 24'h7FFFFE);
    exp_q.push_back({24'h800001, 24'h7FFFFE});
    check_frame("normal", 4);

    collide(4, 24'h123456, 24'h654321);
    exp_q.push_back({24'h123456, 24'h654321});
    check_frame("collide", 4);

    for (int f = 0; f < 3; f++) begin
      exp_q.push_back({24'h123456, 24'h654321});
      check_frame("hold", 4);
    end

    pulse(24'hAAAAAA, 24'h0F0F0F);
    pulse(24'h555555, 24'h333333);
    exp_q.push_back({24'h555555, 24'h333333});
    check_frame("overwrite", 4);

    collect(40, bits, span, lr_ok, to);
    chk("midrst_timeout", 64'(to), 64'd0);
    rst4 = 1'b1;
    #1;
    chk("midrst_bclk", 64'(m_bclk), 64'd0);
    chk("midrst_lrclk", 64'(m_lrclk), 64'd1);
    chk("midrst_sdata", 64'(m_sdata), 64'd0);
    chk("midrst_taken", 64'(m_taken), 64'd0);
    tick();
    tick();
    rst4 = 1'b0;
    release_and_check_start("restart");
    exp_q.push_back(48'd0);
    check_frame("post_reset", 4);

    rst4 = 1'b1;
    sel = 1'b1;
    tick();
    rst1 = 1'b0;
    pulse(24'hABCDEF, 24'hFEDCBA);
    tick();
    chk("div1_taken", 64'(m_taken), 64'd1);
    chk("div1_lrclk", 64'(m_lrclk), 64'd0);
    exp_q.push_back({24'hABCDEF, 24'hFEDCBA});
    check_frame("div1", 1);

    collide(1, 24'h5A5A5A, 24'hA5A5A5);
    exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
    check_frame("div1_coll", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
